// File: rtl/logic_tile_config_chain.sv
// Logic tile configuration chain.
// Multi-lane serial shift-in feeds a CONFIG_WIDTH-bit chain. A commit copies
// the chain into the active register only when exactly WORDS words were
// shifted. A capture reloads the chain from the active register for readback.
module logic_tile_config_chain #(
  parameter int unsigned CONFIG_WIDTH = 524,
  parameter int unsigned SERIAL_WIDTH = 1
) (
  input  logic                                                 config_clock,
  input  logic                                                 config_nreset,
  input  logic                                                 config_enable,
  input  logic [SERIAL_WIDTH-1:0]                              config_in,
  output logic [SERIAL_WIDTH-1:0]                              config_out,
  input  logic                                                 config_commit,
  input  logic                                                 config_capture,
  output logic [CONFIG_WIDTH-1:0]                              config_data,
  output logic [$clog2(CONFIG_WIDTH/SERIAL_WIDTH+2)-1:0]       config_count,
  output logic                                                 config_valid,
  output logic                                                 config_error
);

  localparam int unsigned WORDS = CONFIG_WIDTH / SERIAL_WIDTH;
  localparam int unsigned CW    = $clog2(WORDS + 2);

  // Count value that marks an exact image, and the saturated overshift value.
  localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);
  localparam logic [CW-1:0] CNT_OVER = CW'(WORDS + 1);

  // Elaboration guard: the chain must hold a whole number of words.
  generate
    if ((CONFIG_WIDTH % SERIAL_WIDTH) != 0) begin : g_bad_width
      $error("CONFIG_WIDTH must be a multiple of SERIAL_WIDTH");
    end
  endgenerate

  logic [CONFIG_WIDTH-1:0] sr_q,    sr_d;
  logic [CONFIG_WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic [CONFIG_WIDTH-1:0] sr_shift;

  // Chain contents after one word shift; a single-word chain simply reloads.
  generate
    if (SERIAL_WIDTH == CONFIG_WIDTH) begin : g_single_word
      assign sr_shift = config_in;
    end else begin : g_multi_word
      assign sr_shift = {sr_q[CONFIG_WIDTH-SERIAL_WIDTH-1:0], config_in};
    end
  endgenerate

  // Next-state selection with priority commit > capture > shift > hold.
  always_comb begin
    sr_d    = sr_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    error_d = error_q;
    if (config_commit) begin
      if (count_q == CNT_FULL) begin
        data_d  = sr_q;
        valid_d = 1'b1;
        error_d = 1'b0;
      end else begin
        error_d = 1'b1;
      end
      count_d = '0;
    end else if (config_capture) begin
      sr_d    = data_q;
      count_d = CNT_FULL;
    end else if (config_enable) begin
      sr_d = sr_shift;
      if (count_q != CNT_OVER) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // State registers; synchronous active-low reset wins over everything.
  always_ff @(posedge config_clock) begin
    if (!config_nreset) begin
      sr_q    <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Top word of the chain drives the daisy-chain output.
  assign config_out   = sr_q[CONFIG_WIDTH-1 -: SERIAL_WIDTH];
  assign config_data  = data_q;
  assign config_count = count_q;
  assign config_valid = valid_q;
  assign config_error = error_q;

endmodule

// File: tb/tb_logic_tile_config_chain.sv
// Scoreboard bench for logic_tile_config_chain: a small 8x2 instance and a
// default 524x1 instance, checked against a word-queue reference model.
module tb_logic_tile_config_chain;

  localparam int unsigned BW = 524;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: CONFIG_WIDTH=8, SERIAL_WIDTH=2
  logic       s_nrst = 1'b0, s_en = 1'b0, s_cm = 1'b0, s_cp = 1'b0;
  logic [1:0] s_in = '0, s_out;
  logic [7:0] s_data;
  logic [2:0] s_cnt;
  logic       s_valid, s_err;

  // Default instance: CONFIG_WIDTH=524, SERIAL_WIDTH=1
  logic          b_nrst = 1'b0, b_en = 1'b0, b_cm = 1'b0, b_cp = 1'b0;
  logic [0:0]    b_in = '0, b_out;
  logic [BW-1:0] b_data;
  logic [9:0]    b_cnt;
  logic          b_valid, b_err;

  logic_tile_config_chain #(.CONFIG_WIDTH(8), .SERIAL_WIDTH(2)) u_small (
    .config_clock(clk), .config_nreset(s_nrst), .config_enable(s_en),
    .config_in(s_in), .config_out(s_out), .config_commit(s_cm),
    .config_capture(s_cp), .config_data(s_data), .config_count(s_cnt),
    .config_valid(s_valid), .config_error(s_err));

  logic_tile_config_chain u_big (
    .config_clock(clk), .config_nreset(b_nrst), .config_enable(b_en),
    .config_in(b_in), .config_out(b_out), .config_commit(b_cm),
    .config_capture(b_cp), .config_data(b_data), .config_count(b_cnt),
    .config_valid(b_valid), .config_error(b_err));

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    else pass_cnt++;
  endtask

  // Reference model: chain and active image as queues of words, oldest first.
  int         nw, sw;
  bit         sel;
  logic [1:0] m_chain[$];
  logic [1:0] m_active[$];
  int         m_cnt;
  bit         m_valid, m_err;

  typedef struct {
    bit            sel;
    logic [1:0]    out;
    logic [BW-1:0] data;
    int            cnt;
    bit            valid;
    bit            err;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    m_chain = {};
    m_active = {};
    for (int i = 0; i < nw; i++) begin
      m_chain.push_back(2'b00);
      m_active.push_back(2'b00);
    end
    m_cnt = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(bit rstn, bit en, bit cm, bit cp, logic [1:0] din);
    logic [1:0] w;
    w = (sw == 1) ? {1'b0, din[0]} : din;
    if (!rstn) model_reset();
    else if (cm) begin
      if (m_cnt == nw) begin m_active = m_chain; m_valid = 1; m_err = 0; end
      else m_err = 1;
      m_cnt = 0;
    end else if (cp) begin
      m_chain = m_active;
      m_cnt = nw;
    end else if (en) begin
      void'(m_chain.pop_front());
      m_chain.push_back(w);
      if (m_cnt < nw + 1) m_cnt++;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.sel = sel;
    e.out = m_chain[0];
    e.data = '0;
    foreach (m_active[i]) e.data = (e.data << sw) | BW'(m_active[i]);
    e.cnt = m_cnt;
    e.valid = m_valid;
    e.err = m_err;
    sb.push_back(e);
  endtask

  // One clock of stimulus to the selected instance; expectation queued after the edge.
  task automatic step(bit rstn, bit en, bit cm, bit cp, logic [1:0] din);
    @(negedge clk);
    if (!sel) begin
      s_nrst = rstn; s_en = en; s_cm = cm; s_cp = cp; s_in = din;
    end else begin
      b_nrst = rstn; b_en = en; b_cm = cm; b_cp = cp; b_in = din[0];
    end
    @(posedge clk);
    cyc++;
    model_step(rstn, en, cm, cp, din);
    push_exp();
  endtask

  task automatic shift(logic [1:0] din);
    step(1, 1, 0, 0, din);
  endtask

  task automatic rand_word(output logic [1:0] w);
    w = 2'($urandom_range(0, 3));
  endtask

  // Monitor: compare every queued expectation against the sampled outputs.
  always @(negedge clk) begin
    exp_t          e;
    logic [1:0]    ao;
    logic [BW-1:0] ad;
    int            ac;
    bit            av, ae;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        ao = {1'b0, b_out}; ad = b_data; ac = int'(b_cnt); av = b_valid; ae = b_err;
      end else begin
        ao = s_out; ad = {516'b0, s_data}; ac = int'(s_cnt); av = s_valid; ae = s_err;
      end
      check("config_out",   BW'(ao), BW'(e.out));
      check("config_data",  ad, e.data);
      check("config_count", BW'(ac), BW'(e.cnt));
      check("config_valid", BW'(av), BW'(e.valid));
      check("config_error", BW'(ae), BW'(e.err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] w;
    int r;
    int n;

    // ---------------- small instance ----------------
    sel = 0; nw = 4; sw = 2; model_reset();
    b_nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_word(w); step(0, 1, 0, 0, w); end

    // Exact load
    shift(2'b10); shift(2'b01); shift(2'b11); shift(2'b00);
    step(1, 0, 1, 0, 2'b00);
    #1 check("exact_load_data", BW'(s_data), BW'(8'b1001_1100));

    // Undershift, overshift, then a clean exact reload of the same image
    for (int i = 0; i < 3; i++) begin rand_word(w); shift(w); end
    step(1, 0, 1, 0, 2'b00);
    for (int i = 0; i < 6; i++) begin rand_word(w); shift(w); end
    #1 check("overshift_count", BW'(s_cnt), BW'(3'd5));
    step(1, 0, 1, 0, 2'b00);
    shift(2'b10); shift(2'b01); shift(2'b11); shift(2'b00);
    step(1, 0, 1, 0, 2'b00);

    // Readback, then capture followed by an immediate commit
    step(1, 0, 0, 1, 2'b00);
    #1 check("readback_first", BW'(s_out), BW'(2'b10));
    for (int i = 0; i < 3; i++) shift(2'b00);
    step(1, 0, 0, 1, 2'b00);
    step(1, 0, 1, 0, 2'b00);

    // Commit + capture + enable together at count 4
    for (int i = 0; i < 4; i++) begin rand_word(w); shift(w); end
    rand_word(w);
    step(1, 1, 1, 1, w);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      rand_word(w);
      step(r != 0, $urandom_range(0, 3) != 0, r >= 1 && r < 9, r >= 9 && r < 15, w);
    end

    // ---------------- default instance ----------------
    @(negedge clk);
    s_nrst = 1'b1; s_en = 0; s_cm = 0; s_cp = 0;
    sel = 1; nw = 524; sw = 1; model_reset();
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 2'($urandom_range(0, 1)));

    for (int i = 0; i < 524; i++) shift(2'($urandom_range(0, 1)));
    step(1, 0, 1, 0, 2'b00);
    for (int i = 0; i < 525; i++) shift(2'($urandom_range(0, 1)));
    step(1, 0, 1, 0, 2'b00);
    #1 check("overshift_525_error", BW'(b_err), BW'(1'b1));

    // Bursts near the exact length with gaps, readback and occasional reset
    for (int k = 0; k < 6; k++) begin
      n = 522 + $urandom_range(0, 4);
      while (n > 0) begin
        if ($urandom_range(0, 7) == 0) step(1, 0, 0, 0, 2'b00);
        else begin shift(2'($urandom_range(0, 1))); n--; end
      end
      step(1, 0, 1, 0, 2'b00);
      if ($urandom_range(0, 1) == 1) begin
        step(1, 0, 0, 1, 2'b00);
        for (int i = 0; i < 20; i++) shift(2'($urandom_range(0, 1)));
      end
      if (k == 3) step(0, 1, 0, 0, 2'b01);
    end

    repeat (2) @(negedge clk);
    #1 check("scoreboard_drained", BW'(sb.size()), BW'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
